// File: rtl/wb_ledbar_pkg.sv
// -----------------------------------------------------------------------------
// wb_ledbar_pkg
// Shared types and constants for the blinktLEDBar Wishbone arbiter slice.
//   arb_state_t          : arbiter FSM state (IDLE, BUSY)
//   NUM_MASTERS          : number of Wishbone masters sharing the LED bar
//   LEDBAR_*_WIDTH       : default bus widths, reused by the blinktLEDBar benches
//   idx_to_onehot()      : master index -> one-hot grant vector
// -----------------------------------------------------------------------------
package wb_ledbar_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int NUM_MASTERS         = 2;
  localparam int LEDBAR_DATA_WIDTH   = 32;
  localparam int LEDBAR_ADDR_WIDTH   = 32;
  localparam int LEDBAR_SELECT_WIDTH = LEDBAR_DATA_WIDTH / 8;

  // Two masters only, so the index is a single bit.
  function automatic logic [NUM_MASTERS-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_rr_grant.sv
// -----------------------------------------------------------------------------
// wb_rr_grant
// Two-request round-robin pick, purely combinational.
//   req   : per-master request (CYC), bit 0 = master 0
//   last  : index of the master served in the previous tenure
//   valid : at least one request present
//   idx   : winning master; on a tie the master that was not served last wins
// -----------------------------------------------------------------------------
module wb_rr_grant
  import wb_ledbar_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   last,
  output logic                   valid,
  output logic                   idx
);

  // NOTE: every variable written in always_comb gets a default assignment first,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    valid = |req;
    idx   = 1'b0;
    case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/wb_ledbar_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ledbar_arbiter
// Two-master Wishbone classic round-robin arbiter in front of one blinktLEDBar
// slave. A grant is held for a whole bus tenure (while the owner keeps CYC
// high); responses are routed back combinationally to the owner only. A
// per-tenure watchdog turns a strobe stalled for TIMEOUT_CYCLES into a local
// ERR so a hung slave cannot lock the LED bar (TIMEOUT_CYCLES = 0 disables it).
//
// Ports
//   i_clk, i_rst_n     : clock (rising edge), asynchronous active-low reset
//   m_cyc_i/stb_i/we_i : per-master control, bit 0 = master 0
//   m_adr_i/dat_i/sel_i: per-master buses packed side by side, master 0 in LSBs
//   m_dat_o            : read data to all masters (straight from s_dat_i)
//   m_ack/err/rty_o    : per-master responses, only the owner's bit can assert
//   s_*_o / s_*_i      : the single slave port
//   o_grant            : one-hot current owner, 00 when idle
//   o_timeout          : one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module wb_ledbar_arbiter
  import wb_ledbar_pkg::*;
#(
  parameter int DATA_WIDTH     = LEDBAR_DATA_WIDTH,
  parameter int ADDR_WIDTH     = LEDBAR_ADDR_WIDTH,
  parameter int SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  // master side
  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,
  output logic [NUM_MASTERS-1:0]              m_rty_o,
  // slave side
  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [SELECT_WIDTH-1:0]             s_sel_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_err_i,
  input  logic                                s_rty_i,
  // status
  output logic [NUM_MASTERS-1:0]              o_grant,
  output logic                                o_timeout
);

  // Watchdog counter width; kept at least one bit so TIMEOUT_CYCLES = 0 still
  // elaborates (the counter then simply never leaves zero).
  localparam int              WD_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  arb_state_t      state;
  logic            g;      // current owner index
  logic            last;   // owner of the previous tenure
  logic [WD_W-1:0] wd;     // consecutive stalled-strobe edges

  logic            req_valid;
  logic            req_idx;
  logic            timeout;
  logic            slave_resp;

  wb_rr_grant u_rr_grant (
    .req   (m_cyc_i),
    .last  (last),
    .valid (req_valid),
    .idx   (req_idx)
  );

  assign slave_resp = s_ack_i | s_err_i | s_rty_i;
  assign timeout    = (TIMEOUT_CYCLES > 0) && (state == BUSY) && (wd == WD_MAX);
  assign o_timeout  = timeout;

  // Read data is shared; only the owner gets an ACK, so others ignore it.
  assign m_dat_o = s_dat_i;

  // Slave port mux and response routing. In IDLE everything is held at zero
  // so reset (which forces IDLE) clears every output without a clock edge.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    o_grant = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state == BUSY) begin
      s_cyc_o = m_cyc_i[g];
      // The strobe is withheld in the timeout cycle so the slave cannot
      // complete a transfer the master is being told has failed.
      s_stb_o = m_stb_i[g] & m_cyc_i[g] & ~timeout;
      s_we_o  = m_we_i[g];
      s_adr_o = m_adr_i[int'(g)*ADDR_WIDTH   +: ADDR_WIDTH];
      s_dat_o = m_dat_i[int'(g)*DATA_WIDTH   +: DATA_WIDTH];
      s_sel_o = m_sel_i[int'(g)*SELECT_WIDTH +: SELECT_WIDTH];
      o_grant = idx_to_onehot(g);
      // Priority keeps the three response lines mutually exclusive even if
      // the slave misbehaves; the watchdog ERR overrides any late response.
      if (timeout)      m_err_o[g] = 1'b1;
      else if (s_err_i) m_err_o[g] = 1'b1;
      else if (s_rty_i) m_rty_o[g] = 1'b1;
      else if (s_ack_i) m_ack_o[g] = 1'b1;
    end
  end

  // Grant FSM and watchdog.
  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      g     <= 1'b0;
      last  <= 1'b1;     // master 0 wins the first tie after reset
      wd    <= '0;
    end else begin
      case (state)
        IDLE: begin
          wd <= '0;
          if (req_valid) begin
            state <= BUSY;
            g     <= req_idx;
          end
        end
        BUSY: begin
          if (!m_cyc_i[g]) begin
            // Tenure ends; the mandatory idle cycle follows.
            state <= IDLE;
            last  <= g;
            wd    <= '0;
          end else if (s_stb_o && !slave_resp) begin
            // Saturate rather than wrap; in practice the timeout cycle
            // (strobe forced low) clears the counter first.
            if (wd != WD_MAX) wd <= wd + 1'b1;
          end else begin
            wd <= '0;
          end
        end
        default: begin
          state <= IDLE;
          wd    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ledbar_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_ledbar_arbiter
// Directed bench for wb_ledbar_arbiter with a 32-register single-cycle-ACK
// slave model standing in for the blinktLEDBar register file.
// -----------------------------------------------------------------------------
module tb_wb_ledbar_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  logic          i_clk   = 1'b0;
  logic          i_rst_n = 1'b0;
  logic [1:0]    m_cyc_i = '0;
  logic [1:0]    m_stb_i = '0;
  logic [1:0]    m_we_i  = '0;
  logic [2*AW-1:0] m_adr_i = '0;
  logic [2*DW-1:0] m_dat_i = '0;
  logic [2*SW-1:0] m_sel_i = '0;
  logic [DW-1:0] m_dat_o;
  logic [1:0]    m_ack_o, m_err_o, m_rty_o;
  logic          s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0] s_adr_o;
  logic [DW-1:0] s_dat_o;
  logic [SW-1:0] s_sel_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i, s_rty_i;
  logic [1:0]    o_grant;
  logic          o_timeout;

  wb_ledbar_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .SELECT_WIDTH   (SW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .m_cyc_i   (m_cyc_i),
    .m_stb_i   (m_stb_i),
    .m_we_i    (m_we_i),
    .m_adr_i   (m_adr_i),
    .m_dat_i   (m_dat_i),
    .m_sel_i   (m_sel_i),
    .m_dat_o   (m_dat_o),
    .m_ack_o   (m_ack_o),
    .m_err_o   (m_err_o),
    .m_rty_o   (m_rty_o),
    .s_cyc_o   (s_cyc_o),
    .s_stb_o   (s_stb_o),
    .s_we_o    (s_we_o),
    .s_adr_o   (s_adr_o),
    .s_dat_o   (s_dat_o),
    .s_sel_o   (s_sel_o),
    .s_dat_i   (s_dat_i),
    .s_ack_i   (s_ack_i),
    .s_err_i   (s_err_i),
    .s_rty_i   (s_rty_i),
    .o_grant   (o_grant),
    .o_timeout (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  // ---------------------------------------------------------------------------
  // Slave model: 0 = never responds, 1 = ACK every strobe, 2 = ACK held high
  // ---------------------------------------------------------------------------
  int          slave_mode = 1;
  logic [31:0] regs [32];

  always_comb begin
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_rty_i = 1'b0;
    if (slave_mode == 1)      s_ack_i = s_cyc_o & s_stb_o;
    else if (slave_mode == 2) s_ack_i = 1'b1;
    s_dat_i = regs[s_adr_o[4:0]];
  end

  always @(posedge i_clk)
    if (s_ack_i && s_cyc_o && s_stb_o && s_we_o) regs[s_adr_o[4:0]] <= s_dat_o;

  // Response counters for the full-system run.
  logic count_en = 1'b0;
  int   ack_cnt0 = 0;
  int   ack_cnt1 = 0;
  int   err_cnt  = 0;

  always @(posedge i_clk)
    if (count_en) begin
      ack_cnt0 <= ack_cnt0 + int'(m_ack_o[0]);
      ack_cnt1 <= ack_cnt1 + int'(m_ack_o[1]);
      err_cnt  <= err_cnt + int'(m_err_o[0]) + int'(m_err_o[1]);
    end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_master(input int m, input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dat);
    m_cyc_i[m]          = cyc;
    m_stb_i[m]          = stb;
    m_we_i[m]           = we;
    m_adr_i[m*AW +: AW] = adr;
    m_dat_i[m*DW +: DW] = dat;
    m_sel_i[m*SW +: SW] = 4'hF;
  endtask

  // One complete single-transfer tenure: request, wait (bounded) for grant,
  // hold through the committing edge, then release and let the bus go idle.
  task automatic wb_write(input int m, input logic [31:0] adr, input logic [31:0] dat);
    logic [1:0] exp_oh;
    exp_oh = (m == 0) ? 2'b01 : 2'b10;
    set_master(m, 1'b1, 1'b1, 1'b1, adr, dat);
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_grant == exp_oh) break;
    end
    check($sformatf("wr%0d_grant_m%0d", adr, m), o_grant, exp_oh);
    check($sformatf("wr%0d_ack_m%0d", adr, m), m_ack_o, exp_oh);
    tick();
    set_master(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // ---- reset state: outputs zero even with master buses non-zero ----------
    set_master(0, 1'b0, 1'b1, 1'b1, 32'hDEAD_0000, 32'hCAFE_0000);
    set_master(1, 1'b0, 1'b1, 1'b1, 32'hDEAD_0001, 32'hCAFE_0001);
    #3;
    check("rst_s_cyc",   s_cyc_o,   1'b0);
    check("rst_s_stb",   s_stb_o,   1'b0);
    check("rst_s_adr",   s_adr_o,   32'h0);
    check("rst_s_dat",   s_dat_o,   32'h0);
    check("rst_grant",   o_grant,   2'b00);
    check("rst_resp",    {m_ack_o, m_err_o, m_rty_o, o_timeout}, 7'h0);
    tick();
    i_rst_n = 1'b1;
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ---- master 0 alone: write then read back in one tenure ----------------
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h03, 32'h1122_3344);
    #1;
    check("m0_idle_cyc",  s_cyc_o, 1'b0);
    check("m0_idle_gnt",  o_grant, 2'b00);
    tick();
    check("m0_s_cyc",     s_cyc_o, 1'b1);
    check("m0_s_stb",     s_stb_o, 1'b1);
    check("m0_s_we",      s_we_o,  1'b1);
    check("m0_s_adr",     s_adr_o, 32'h03);
    check("m0_s_dat",     s_dat_o, 32'h1122_3344);
    check("m0_s_sel",     s_sel_o, 4'hF);
    check("m0_grant",     o_grant, 2'b01);
    check("m0_ack",       m_ack_o, 2'b01);
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h03, 32'h0);
    #1;
    check("m0_rd_data",   m_dat_o, 32'h1122_3344);
    check("m0_rd_ack",    m_ack_o, 2'b01);
    tick();
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("m0_drop_cyc",  s_cyc_o, 1'b0);
    check("m0_drop_gnt",  o_grant, 2'b01);
    tick();
    check("m0_rel_gnt",   o_grant, 2'b00);

    // ---- simultaneous requests after reset ---------------------------------
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    tick();
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h11, 32'h0);
    tick();
    check("sim_gnt0",     o_grant, 2'b01);
    check("sim_adr0",     s_adr_o, 32'h10);
    check("sim_ack0",     m_ack_o, 2'b01);
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("sim_gap_gnt",  o_grant, 2'b00);
    check("sim_gap_cyc",  s_cyc_o, 1'b0);
    tick();
    check("sim_gnt1",     o_grant, 2'b10);
    check("sim_adr1",     s_adr_o, 32'h11);
    check("sim_ack1",     m_ack_o, 2'b10);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Alternation: each round both request, the winner is dropped at once.
    for (int r = 0; r < 8; r++) begin
      set_master(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      set_master(1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0);
      tick();
      check($sformatf("alt_round%0d", r), o_grant, (r % 2 == 0) ? 2'b01 : 2'b10);
      set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
    end

    // ---- master 1 locks the bus with STB low --------------------------------
    set_master(1, 1'b1, 1'b0, 1'b0, 32'h7, 32'h0);
    tick();
    check("lock_gnt1",    o_grant, 2'b10);
    set_master(0, 1'b1, 1'b1, 1'b0, 32'h3, 32'h0);
    for (int c = 0; c < 20; c++) begin
      tick();
      check($sformatf("lock_gnt_c%0d", c), o_grant, 2'b10);
      check($sformatf("lock_resp_c%0d", c), {m_ack_o, m_err_o, o_timeout, s_stb_o}, 6'h0);
    end
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("lock_rel_gnt", o_grant, 2'b00);
    check("lock_rel_ack", m_ack_o, 2'b00);
    tick();
    check("lock_m0_gnt",  o_grant, 2'b01);
    check("lock_m0_ack",  m_ack_o, 2'b01);
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ---- watchdog: slave never answers --------------------------------------
    slave_mode = 0;
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h9, 32'hAAAA_5555);
    tick();
    for (int k = 0; k < TO; k++) begin
      check($sformatf("wd_stall%0d_to", k), {o_timeout, m_err_o}, 3'b000);
      check($sformatf("wd_stall%0d_stb", k), s_stb_o, 1'b1);
      tick();
    end
    check("wd_fire_to",   o_timeout, 1'b1);
    check("wd_fire_err",  m_err_o,   2'b01);
    check("wd_fire_stb",  s_stb_o,   1'b0);
    check("wd_fire_gnt",  o_grant,   2'b01);
    check("wd_fire_cyc",  s_cyc_o,   1'b1);
    slave_mode = 2;
    #1;
    check("wd_supp_ack",  m_ack_o,   2'b00);
    check("wd_supp_err",  m_err_o,   2'b01);
    slave_mode = 0;
    tick();
    check("wd_after_to",  {o_timeout, m_err_o}, 3'b000);
    check("wd_after_stb", s_stb_o,   1'b1);
    check("wd_after_gnt", o_grant,   2'b01);
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    check("wd_rel_gnt",   o_grant,   2'b00);
    slave_mode = 1;

    // ---- asynchronous reset mid-strobe --------------------------------------
    set_master(0, 1'b1, 1'b1, 1'b1, 32'h5, 32'h5555_0000);
    tick();
    check("arst_pre_cyc", s_cyc_o, 1'b1);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_cyc",     s_cyc_o, 1'b0);
    check("arst_stb",     s_stb_o, 1'b0);
    check("arst_bus",     {s_we_o, s_adr_o, s_dat_o, s_sel_o}, 69'h0);
    check("arst_grant",   o_grant, 2'b00);
    check("arst_resp",    {m_ack_o, m_err_o, m_rty_o, o_timeout}, 7'h0);
    tick();
    tick();
    set_master(1, 1'b1, 1'b1, 1'b0, 32'h1, 32'h0);
    i_rst_n = 1'b1;
    tick();
    check("arst_tie_gnt", o_grant, 2'b01);
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_master(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // ---- full system: alternate masters write registers 0..31 --------------
    count_en = 1'b1;
    for (int i = 0; i < 32; i++) wb_write(i % 2, i, 32'h1122_3344 + i);
    count_en = 1'b0;
    #1;
    check("sys_ack_m0",   ack_cnt0, 16);
    check("sys_ack_m1",   ack_cnt1, 16);
    check("sys_err",      err_cnt,  0);

    set_master(0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 32; i++) begin
      m_adr_i[AW-1:0] = i;
      #1;
      check($sformatf("sys_rd%0d", i), m_dat_o, 32'h1122_3344 + i);
      tick();
    end
    set_master(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
